// File: rtl/spi_rgb_regs.sv
// SPI mode-0 slave register front end: oversamples SCK/CS/MOSI in the clk domain,
// commits RGB levels and mode atomically, and shifts committed levels out on MISO.
module spi_rgb_regs #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] RESET_R     = 8'h00,
  parameter logic [7:0] RESET_G     = 8'h00,
  parameter logic [7:0] RESET_B     = 8'h00,
  parameter logic [1:0] RESET_MODE  = 2'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_sck,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic [7:0] level_r,
  output logic [7:0] level_g,
  output logic [7:0] level_b,
  output logic [1:0] mode,
  output logic       update,
  output logic       frame_err,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    WAIT_CS = 3'd0,
    IDLE    = 3'd1,
    CMD     = 3'd2,
    DATA    = 3'd3,
    IGNORE  = 3'd4
  } state_t;

  localparam logic [7:0] CMD_WR_RGB  = 8'h01;
  localparam logic [7:0] CMD_WR_MODE = 8'h02;
  localparam logic [7:0] CMD_RD_RGB  = 8'h80;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
  logic sck_s, cs_s, mosi_s, sck_d, cs_d;
  logic sck_rise, sck_fall, cs_start, cs_end;

  logic [2:0]  bit_cnt;
  logic [1:0]  byte_cnt;
  logic [7:0]  shift_q, cmd_q, stage_r, stage_g;
  logic [7:0]  new_byte;
  logic [23:0] rd_sh;
  logic        rd_skip, last_byte;

  logic restart, clear_frame, shift_en, cmd_done, data_byte_done;
  logic err_now, commit_rgb, commit_mode, load_rd;

  // CS chain resets to "selected" so a frame already running at reset release
  // is held off in WAIT_CS until the host really deasserts chip select.
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync  <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sck_d     <= 1'b0;
      cs_d      <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      sck_d     <= sck_s;
      cs_d      <= cs_s;
    end
  end

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign cs_start = ~cs_s & cs_d;
  assign cs_end   = cs_s & ~cs_d;

  assign new_byte  = {shift_q[6:0], mosi_s};
  assign last_byte = (cmd_q == CMD_WR_MODE) ? (byte_cnt == 2'd0) : (byte_cnt == 2'd2);

  always_ff @(posedge clk) begin
    if (rst) state <= WAIT_CS;
    else     state <= state_next;
  end

  // cs_end is tested before sck_rise so a coincident rise is dropped.
  always_comb begin
    state_next     = state;
    restart        = 1'b0;
    clear_frame    = 1'b0;
    shift_en       = 1'b0;
    cmd_done       = 1'b0;
    data_byte_done = 1'b0;
    err_now        = 1'b0;
    commit_rgb     = 1'b0;
    commit_mode    = 1'b0;
    load_rd        = 1'b0;
    case (state)
      WAIT_CS: if (cs_s) state_next = IDLE;
      IDLE: begin
        if (cs_start) begin
          state_next = CMD;
          restart    = 1'b1;
        end
      end
      default: begin
        if (cs_end) begin
          state_next  = IDLE;
          clear_frame = 1'b1;
          err_now     = (state != IGNORE);
        end else if (cs_start) begin
          state_next = CMD;
          restart    = 1'b1;
        end else if (sck_rise && state != IGNORE) begin
          shift_en = 1'b1;
          if (bit_cnt == 3'd7) begin
            if (state == CMD) begin
              cmd_done = 1'b1;
              case (new_byte)
                CMD_WR_RGB, CMD_WR_MODE: state_next = DATA;
                CMD_RD_RGB: begin
                  state_next = DATA;
                  load_rd    = 1'b1;
                end
                default: begin
                  state_next = IGNORE;
                  err_now    = 1'b1;
                end
              endcase
            end else begin
              data_byte_done = 1'b1;
              if (last_byte) begin
                state_next  = IGNORE;
                commit_rgb  = (cmd_q == CMD_WR_RGB);
                commit_mode = (cmd_q == CMD_WR_MODE);
              end
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt   <= 3'd0;
      byte_cnt  <= 2'd0;
      shift_q   <= 8'h00;
      cmd_q     <= 8'h00;
      stage_r   <= 8'h00;
      stage_g   <= 8'h00;
      level_r   <= RESET_R;
      level_g   <= RESET_G;
      level_b   <= RESET_B;
      mode      <= RESET_MODE;
      update    <= 1'b0;
      frame_err <= 1'b0;
      rd_sh     <= 24'h0;
      rd_skip   <= 1'b0;
    end else begin
      update    <= commit_rgb | commit_mode;
      frame_err <= err_now;
      if (restart || clear_frame) begin
        bit_cnt  <= 3'd0;
        byte_cnt <= 2'd0;
        shift_q  <= 8'h00;
        stage_r  <= 8'h00;
        stage_g  <= 8'h00;
      end else if (shift_en) begin
        shift_q <= new_byte;
        bit_cnt <= bit_cnt + 3'd1;
        if (cmd_done) cmd_q <= new_byte;
        if (data_byte_done) begin
          if (byte_cnt == 2'd0) stage_r <= new_byte;
          if (byte_cnt == 2'd1) stage_g <= new_byte;
          byte_cnt <= byte_cnt + 2'd1;
        end
      end
      // The final byte goes straight from the shifter so all levels land together.
      if (commit_rgb) begin
        level_r <= stage_r;
        level_g <= stage_g;
        level_b <= new_byte;
      end
      if (commit_mode) mode <= new_byte[1:0];
      if (load_rd) begin
        rd_sh   <= {level_r, level_g, level_b};
        rd_skip <= 1'b1;
      end else if (sck_fall && state == DATA) begin
        if (rd_skip) rd_skip <= 1'b0;
        else         rd_sh   <= {rd_sh[22:0], 1'b0};
      end
    end
  end

  assign spi_miso  = (state == DATA && cmd_q == CMD_RD_RGB) ? rd_sh[23] : 1'b0;
  assign dbg_state = state;

endmodule

// File: tb/tb_spi_rgb_regs.sv
// Directed bench for spi_rgb_regs: expected update/frame_err events and MISO bits
// are queued by the driver and checked by forked monitors.
module tb_spi_rgb_regs;

  logic       clk = 1'b0;
  logic       rst;
  logic       spi_sck, spi_cs_n, spi_mosi;
  logic       spi_miso;
  logic [7:0] level_r, level_g, level_b;
  logic [1:0] mode;
  logic       update, frame_err;
  logic [2:0] dbg_state;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  logic rd_active = 1'b0;

  // Event entry: {cycle, update, frame_err, level_r, level_g, level_b, mode}
  logic [59:0] exp_q[$];
  logic        miso_q[$];

  logic [7:0] m_r, m_g, m_b;
  logic [1:0] m_mode;

  spi_rgb_regs dut (
    .clk       (clk),
    .rst       (rst),
    .spi_sck   (spi_sck),
    .spi_cs_n  (spi_cs_n),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso),
    .level_r   (level_r),
    .level_g   (level_g),
    .level_b   (level_b),
    .mode      (mode),
    .update    (update),
    .frame_err (frame_err),
    .dbg_state (dbg_state)
  );

  // clock / cycle counter
  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  function automatic logic [27:0] ev_upd(input logic [7:0] r, g, b, input logic [1:0] md);
    return {2'b10, r, g, b, md};
  endfunction

  function automatic logic [27:0] ev_err();
    return {2'b01, m_r, m_g, m_b, m_mode};
  endfunction

  // driver tasks: sck period is 8 clk, MOSI changes with sck low
  task automatic send_bits(input logic [7:0] b, input int n, input logic push_en,
                           input logic [27:0] ev);
    for (int i = 0; i < n; i++) begin
      spi_mosi = b[7-i];
      repeat (4) @(negedge clk);
      spi_sck = 1'b1;
      if (push_en && i == n - 1) exp_q.push_back({cyc + 32'd3, ev});
      repeat (4) @(negedge clk);
      spi_sck = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(b, 8, 1'b0, 28'h0);
  endtask

  task automatic cs_low();
    spi_cs_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_high(input logic push_en, input logic [27:0] ev);
    spi_cs_n = 1'b1;
    if (push_en) exp_q.push_back({cyc + 32'd3, ev});
    repeat (8) @(negedge clk);
  endtask

  task automatic write_rgb(input logic [7:0] r, g, b);
    cs_low();
    send_byte(8'h01);
    send_byte(r);
    send_byte(g);
    send_bits(b, 8, 1'b1, ev_upd(r, g, b, m_mode));
    m_r = r; m_g = g; m_b = b;
    cs_high(1'b0, 28'h0);
  endtask

  task automatic write_mode(input logic [7:0] v);
    cs_low();
    send_byte(8'h02);
    send_bits(v, 8, 1'b1, ev_upd(m_r, m_g, m_b, v[1:0]));
    m_mode = v[1:0];
    cs_high(1'b0, 28'h0);
  endtask

  // scoreboard monitor: every update/frame_err cycle pops one expected event
  task automatic mon_events();
    logic [59:0] act, exp;
    logic [25:0] prev;
    prev = {level_r, level_g, level_b, mode};
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (update || frame_err) begin
          act = {cyc, update, frame_err, level_r, level_g, level_b, mode};
          if (exp_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL event_unexpected act=%h", act);
          end else begin
            exp = exp_q.pop_front();
            n_checks++;
            if (act !== exp) begin
              n_err++;
              $display("FAIL event act=%h exp=%h", act, exp);
            end
          end
        end
        if ({level_r, level_g, level_b, mode} != prev) chk("change_has_update", {31'd0, update}, 32'd1);
      end
      prev = {level_r, level_g, level_b, mode};
    end
  endtask

  task automatic mon_miso();
    logic e;
    forever begin
      @(posedge spi_sck);
      if (rd_active) begin
        if (miso_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL miso_unexpected act=%b", spi_miso);
        end else begin
          e = miso_q.pop_front();
          chk("miso_bit", {31'd0, spi_miso}, {31'd0, e});
        end
      end
    end
  endtask

  initial begin
    logic [23:0] rd_val;
    rst = 1'b1; spi_sck = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
    m_r = 8'h00; m_g = 8'h00; m_b = 8'h00; m_mode = 2'd0;
    repeat (3) @(negedge clk);
    chk("rst_level_r", {24'd0, level_r}, 32'h00);
    chk("rst_level_g", {24'd0, level_g}, 32'h00);
    chk("rst_level_b", {24'd0, level_b}, 32'h00);
    chk("rst_mode", {30'd0, mode}, 32'd0);
    chk("rst_strobes", {30'd0, update, frame_err}, 32'd0);
    chk("rst_miso", {31'd0, spi_miso}, 32'd0);
    chk("rst_state", {29'd0, dbg_state}, 32'd0);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    fork
      mon_events();
      mon_miso();
      begin
        #400000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
      end
    join_none

    write_rgb(8'h40, 8'h80, 8'hC0);
    chk("mode_after_rgb", {30'd0, mode}, 32'd0);
    write_mode(8'h03);
    write_mode(8'h01);
    chk("mode_is_1", {30'd0, mode}, 32'd1);

    // 02 then 4 sck rises and CS release: error, mode kept
    cs_low();
    send_byte(8'h02);
    send_bits(8'hF0, 4, 1'b0, 28'h0);
    cs_high(1'b1, ev_err());
    chk("mode_kept", {30'd0, mode}, 32'd1);

    // read-back of 12/34/56
    write_rgb(8'h12, 8'h34, 8'h56);
    rd_val = 24'h123456;
    for (int i = 23; i >= 0; i--) miso_q.push_back(rd_val[i]);
    cs_low();
    send_byte(8'h80);
    rd_active = 1'b1;
    send_byte(8'hFF);
    send_byte(8'h00);
    send_byte(8'hFF);
    rd_active = 1'b0;
    chk("miso_after_24", {31'd0, spi_miso}, 32'd0);
    send_byte(8'hFF);
    chk("miso_extra_byte", {31'd0, spi_miso}, 32'd0);
    cs_high(1'b0, 28'h0);
    chk("miso_cs_high", {31'd0, spi_miso}, 32'd0);
    chk("miso_q_empty", miso_q.size(), 32'd0);

    // truncated write
    cs_low();
    send_byte(8'h01);
    send_byte(8'hAA);
    send_byte(8'hBB);
    cs_high(1'b1, ev_err());
    chk("trunc_levels", {8'd0, level_r, level_g, level_b}, 32'h00123456);

    // unknown command
    cs_low();
    send_bits(8'h7F, 8, 1'b1, ev_err());
    send_byte(8'h00);
    cs_high(1'b0, 28'h0);
    chk("unknown_levels", {8'd0, level_r, level_g, level_b}, 32'h00123456);

    // surplus bytes after a complete write
    cs_low();
    send_byte(8'h01);
    send_byte(8'h11);
    send_byte(8'h22);
    send_bits(8'h33, 8, 1'b1, ev_upd(8'h11, 8'h22, 8'h33, m_mode));
    m_r = 8'h11; m_g = 8'h22; m_b = 8'h33;
    send_byte(8'h44);
    send_byte(8'h55);
    cs_high(1'b0, 28'h0);
    chk("surplus_levels", {8'd0, level_r, level_g, level_b}, 32'h00112233);

    // reset in the middle of a frame
    cs_low();
    send_byte(8'h01);
    send_bits(8'hAA, 4, 1'b0, 28'h0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    m_r = 8'h00; m_g = 8'h00; m_b = 8'h00; m_mode = 2'd0;
    chk("midrst_levels", {8'd0, level_r, level_g, level_b}, 32'h0);
    chk("midrst_mode", {30'd0, mode}, 32'd0);
    chk("midrst_state", {29'd0, dbg_state}, 32'd0);
    rst = 1'b0;
    send_bits(8'hA0, 4, 1'b0, 28'h0);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    chk("postrst_levels", {8'd0, level_r, level_g, level_b}, 32'h0);
    chk("postrst_state", {29'd0, dbg_state}, 32'd0);
    cs_high(1'b0, 28'h0);
    write_rgb(8'h01, 8'h02, 8'h03);
    chk("fresh_levels", {8'd0, level_r, level_g, level_b}, 32'h00010203);

    repeat (10) @(negedge clk);
    chk("exp_q_empty", exp_q.size(), 32'd0);
    chk("end_state", {29'd0, dbg_state}, 32'd1);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
